// File: rtl/button_counter.sv
// Debounced push-button press counter driving two 8-bit LED banks.
// Optional auto-repeat while held is enabled by defining HOLD_REPEAT_EN.
module button_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button,
    output logic [7:0] left_leds,
    output logic [7:0] right_leds,
    output logic       press_pulse,
    output logic       pressed
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] DEB_PRESS   = 2'd1;
    localparam logic [1:0] HELD        = 2'd2;
    localparam logic [1:0] DEB_RELEASE = 2'd3;

    // Declaration initialisers give the power-on values without a reset edge.
    logic          sync1_q       = 1'b0;
    logic          sync2_q       = 1'b0;
    logic [1:0]    state_q       = IDLE;
    logic [1:0]    state_d;
    logic [DW-1:0] deb_cnt_q     = '0;
    logic [DW-1:0] deb_cnt_d;
    logic [15:0]   count_q       = 16'h0000;
    logic [15:0]   count_d;
    logic          press_pulse_q = 1'b0;
    logic          press_pulse_d;
    logic          accept;
    logic          bump;

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d   = DEB_PRESS;
                    deb_cnt_d = '0;
                end
            end
            DEB_PRESS: begin
                if (!sync2_q) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = HELD;
                    deb_cnt_d = '0;
                    accept    = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    state_d   = DEB_RELEASE;
                    deb_cnt_d = '0;
                end
            end
            DEB_RELEASE: begin
                // Returning high here is a release bounce: back to HELD, no count.
                if (sync2_q) begin
                    state_d   = HELD;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                deb_cnt_d = '0;
            end
        endcase
    end

`ifdef HOLD_REPEAT_EN
    localparam int unsigned RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt_q = '0;
    logic [RW-1:0] rep_cnt_d;
    logic          repeat_fire;

    // Outside steady HELD-high the counter sits at zero, so entering HELD
    // (including from a release bounce) always restarts the repeat period.
    always_comb begin
        rep_cnt_d   = '0;
        repeat_fire = 1'b0;
        if (state_q == HELD && sync2_q) begin
            if (rep_cnt_q == REP_LAST) begin
                repeat_fire = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end

    assign bump = accept | repeat_fire;
`else
    logic unused_repeat_cycles;
    assign unused_repeat_cycles = ^REPEAT_CYCLES;
    assign bump = accept;
`endif

    assign count_d       = count_q + 16'd1;
    assign press_pulse_d = bump;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            state_q       <= IDLE;
            deb_cnt_q     <= '0;
            count_q       <= 16'h0000;
            press_pulse_q <= 1'b0;
        end else begin
            sync1_q       <= button;
            sync2_q       <= sync1_q;
            state_q       <= state_d;
            deb_cnt_q     <= deb_cnt_d;
            press_pulse_q <= press_pulse_d;
            if (bump) begin
                count_q <= count_d;
            end
        end
    end

    assign left_leds   = count_q[15:8];
    assign right_leds  = count_q[7:0];
    assign press_pulse = press_pulse_q;
    assign pressed     = (state_q == HELD) || (state_q == DEB_RELEASE);

endmodule

// File: tb/tb_button_counter.sv
// Self-checking bench for button_counter with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Reference model: run-length debounce on the two-cycle delayed button level.
module tb_button_counter;

    localparam int unsigned DEB = 4;
    localparam int unsigned REP = 8;
`ifdef HOLD_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       button;
    logic [7:0] left_leds;
    logic [7:0] right_leds;
    logic       press_pulse;
    logic       pressed;

    button_counter #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .button     (button),
        .left_leds  (left_leds),
        .right_leds (right_leds),
        .press_pulse(press_pulse),
        .pressed    (pressed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: synchronizer delay line, debounced level, length of the
    // current run of samples disagreeing with it, and steady-held run length.
    bit          m_s1, m_s2;
    bit          m_level;
    int          m_run;
    int          m_hold;
    logic [15:0] m_count;
    bit          m_pulse;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_hold = 0;
        m_count = 16'h0000; m_pulse = 0;
    endtask

    task automatic model_edge(input bit b, input bit r);
        if (r) begin
            model_reset();
        end else begin
            m_pulse = 0;
            if (m_s2 != m_level) begin
                m_run++;
                m_hold = 0;
                if (m_run == DEB + 1) begin
                    m_level = m_s2;
                    m_run   = 0;
                    if (m_level) begin
                        m_count++;
                        m_pulse = 1;
                    end
                end
            end else if (m_run != 0) begin
                m_run  = 0;
                m_hold = 0;
            end else if (REP_EN && m_level) begin
                m_hold++;
                if (m_hold == REP) begin
                    m_hold = 0;
                    m_count++;
                    m_pulse = 1;
                end
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check16({tag, ".count"}, {left_leds, right_leds}, m_count);
        check1({tag, ".pulse"}, press_pulse, m_pulse);
        check1({tag, ".pressed"}, pressed, m_level);
    endtask

    // Drive one cycle's inputs, let the edge happen, check at the falling edge.
    task automatic cycle(input logic b, input logic r, input string tag);
        button = b;
        reset  = r;
        @(posedge clock);
        model_edge(b, r);
        @(negedge clock);
        check_all(tag);
    endtask

    initial begin
        int unsigned len;
        bit lvl;
        logic [15:0] exp_cnt;

        button = 1'b0;
        reset  = 1'b1;
        model_reset();

        cycle(1'b0, 1'b1, "reset0");
        cycle(1'b0, 1'b1, "reset1");
        check16("reset_count", {left_leds, right_leds}, 16'h0000);
        check1("reset_pulse", press_pulse, 1'b0);
        check1("reset_pressed", pressed, 1'b0);

        // Clean press held 20 cycles then released 20.
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 1'b0, "clean_hi");
            if (i == 7) check1("clean_pulse_edge7", press_pulse, 1'b1);
            if (i == 6) check1("clean_no_pulse_edge6", press_pulse, 1'b0);
        end
        for (int i = 1; i <= 20; i++) cycle(1'b0, 1'b0, "clean_lo");
        check16("clean_count", {left_leds, right_leds}, 16'h0001);
        check16("clean_leds", {left_leds, right_leds} & 16'hFF00, 16'h0000);

        // Press bounce shorter than the debounce window.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "bounce_hi_a");
        cycle(1'b0, 1'b0, "bounce_lo");
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "bounce_hi_b");
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, "bounce_tail");
        check16("bounce_count", {left_leds, right_leds}, 16'h0001);

        // Release bounce while held: low 2 then high again.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, "rel_bounce_hi");
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, "rel_bounce_lo");
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, "rel_bounce_back");
        check1("rel_bounce_pressed", pressed, 1'b1);
        check16("rel_bounce_count", {left_leds, right_leds}, 16'h0002);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, "rel_bounce_tail");

        // Reset mid-debounce with the button held throughout.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, "mid_deb_hi");
        cycle(1'b1, 1'b1, "mid_deb_reset");
        check16("mid_deb_reset_count", {left_leds, right_leds}, 16'h0000);
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 1'b0, "mid_deb_held");
            if (i == 7) check1("mid_deb_pulse_edge7", press_pulse, 1'b1);
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, "mid_deb_tail");
        check16("mid_deb_count", {left_leds, right_leds}, 16'h0001);

        // Long hold: auto-repeat adds three pulses when enabled.
        cycle(1'b0, 1'b1, "hold_reset");
        for (int i = 0; i < 36; i++) cycle(1'b1, 1'b0, "hold_hi");
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, "hold_lo");
        exp_cnt = REP_EN ? 16'h0004 : 16'h0001;
        check16("hold_count", {left_leds, right_leds}, exp_cnt);

        // Wrap from 0xFFFF to 0x0000 on one press.
        cycle(1'b0, 1'b1, "wrap_reset");
        force dut.count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        cycle(1'b0, 1'b0, "wrap_forced");
        release dut.count_q;
        cycle(1'b0, 1'b0, "wrap_released");
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, "wrap_hi");
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, "wrap_lo");
        check16("wrap_count", {left_leds, right_leds}, 16'h0000);

        // Randomized segments of bouncing and held levels, with rare resets.
        for (int seg = 0; seg < 60; seg++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, (seg % 4 == 0) ? 30 : 8);
            for (int unsigned k = 0; k < len; k++) begin
                cycle(lvl, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, "random");
            end
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, "random_tail");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
